// File: rtl/button_debouncer_bank.sv
// button_debouncer_bank: per-channel 2-flop synchroniser and tick-qualified debounce FSM.
// Define AUTOREPEAT_EN to add hold-to-repeat pulses; otherwise repeat_pulse stays 0.
//
// state   | meaning
// STABLE0 | debounced low, waiting for sync to rise
// ARM1    | sync high, counting ticks towards a press
// STABLE1 | debounced high, waiting for sync to fall
// ARM0    | sync low, counting ticks towards a release
module button_debouncer_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                qzt_clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic [CNT_W-1:0]    limit,
  input  logic [CNT_W-1:0]    hold_limit,
  input  logic [CNT_W-1:0]    repeat_limit,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse
);

  typedef enum logic [1:0] {STABLE0, ARM1, STABLE1, ARM0} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // A zero limit behaves as one tick.
  logic [CNT_W-1:0] limit_eff;
  assign limit_eff = (limit == '0) ? ONE : limit;

`ifdef AUTOREPEAT_EN
  logic [CNT_W-1:0] hold_eff;
  logic [CNT_W-1:0] repeat_eff;
  assign hold_eff   = (hold_limit == '0) ? ONE : hold_limit;
  assign repeat_eff = (repeat_limit == '0) ? ONE : repeat_limit;
`else
  logic unused_limits;
  assign unused_limits = ^{hold_limit, repeat_limit};
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [1:0]       sync;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] cnt_sat;
    logic             qualify;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    // Compare in CNT_W+1 bits so a saturated counter still qualifies.
    assign cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);
    assign cnt_sat = (cnt == '1) ? cnt : cnt_inc[CNT_W-1:0];
    assign qualify = tick && (cnt_inc >= {1'b0, limit_eff});

`ifdef AUTOREPEAT_EN
    logic [CNT_W-1:0] rep_cnt;
    logic             rep_phase;
    logic             rep_q;
    logic [CNT_W:0]   rep_inc;
    logic [CNT_W-1:0] rep_lim;
    logic             rep_fire;

    assign rep_inc  = {1'b0, rep_cnt} + (CNT_W + 1)'(1);
    assign rep_lim  = rep_phase ? repeat_eff : hold_eff;
    assign rep_fire = tick && (rep_inc >= {1'b0, rep_lim});
`endif

    always_ff @(posedge qzt_clk) begin
      if (reset) begin
        sync      <= '0;
        state     <= STABLE0;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef AUTOREPEAT_EN
        rep_cnt   <= '0;
        rep_phase <= 1'b0;
        rep_q     <= 1'b0;
`endif
      end else begin
        sync      <= {sync[0], raw_in[g]};
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef AUTOREPEAT_EN
        // Repeat timing runs through ARM0; exits below override it.
        rep_q <= 1'b0;
        if ((state == STABLE1 || state == ARM0) && tick) begin
          if (rep_fire) begin
            rep_q     <= 1'b1;
            rep_cnt   <= '0;
            rep_phase <= 1'b1;
          end else if (rep_cnt != '1) begin
            rep_cnt <= rep_inc[CNT_W-1:0];
          end
        end
`endif
        case (state)
          STABLE0: begin
            if (sync[1]) begin
              state <= ARM1;
              cnt   <= '0;
            end
          end
          ARM1: begin
            if (!sync[1]) begin
              state <= STABLE0;
              cnt   <= '0;
            end else if (qualify) begin
              state   <= STABLE1;
              cnt     <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
`ifdef AUTOREPEAT_EN
              rep_cnt   <= '0;
              rep_phase <= 1'b0;
              rep_q     <= 1'b0;
`endif
            end else if (tick) begin
              cnt <= cnt_sat;
            end
          end
          STABLE1: begin
            if (!sync[1]) begin
              state <= ARM0;
              cnt   <= '0;
            end
          end
          ARM0: begin
            if (sync[1]) begin
              state <= STABLE1;
              cnt   <= '0;
`ifdef AUTOREPEAT_EN
              rep_cnt   <= '0;
              rep_phase <= 1'b0;
              rep_q     <= 1'b0;
`endif
            end else if (qualify) begin
              state     <= STABLE0;
              cnt       <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
`ifdef AUTOREPEAT_EN
              rep_cnt   <= '0;
              rep_phase <= 1'b0;
              rep_q     <= 1'b0;
`endif
            end else if (tick) begin
              cnt <= cnt_sat;
            end
          end
          default: begin
            state <= STABLE0;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign level[g]         = level_q;
    assign press[g]         = press_q;
    assign release_pulse[g] = release_q;
`ifdef AUTOREPEAT_EN
    assign repeat_pulse[g]  = rep_q;
`else
    assign repeat_pulse[g]  = 1'b0;
`endif
  end

endmodule

// File: doc/button_debouncer_bank.md
# button_debouncer_bank

Parametrised bank of debouncers for the board's push-buttons and slide switches. Each channel synchronises a raw pad input and qualifies every level change against a programmable count of timebase ticks. Each channel then presents a clean level plus one-cycle press and release pulses. The bank sits between the pads and consumers such as the PS/2 trigger logic and LED muxing, and is driven by the 1 ms tick from the frequency divider.

## Interface
- CHANNELS, 4, number of independent debounce channels (1..16)
- CNT_W, 8, width of debounce and repeat counters
- qzt_clk  input  1  system clock (50 MHz)
- reset  input  1  synchronous, active-high reset
- tick  input  1  timebase enable; one qzt_clk cycle high per tick period (e.g. 1 ms)
- raw_in  input  CHANNELS  asynchronous pad inputs, active-high
- limit  input  CNT_W  debounce length in ticks, shared by all channels
- hold_limit  input  CNT_W  ticks held before first auto-repeat (AUTOREPEAT_EN only)
- repeat_limit  input  CNT_W  ticks between subsequent repeats (AUTOREPEAT_EN only)
- level  output  CHANNELS  debounced level
- press  output  CHANNELS  one-cycle pulse on qualified 0->1
- release  output  CHANNELS  one-cycle pulse on qualified 1->0
- repeat  output  CHANNELS  one-cycle auto-repeat pulse while held

## Operation
- Per channel: 2-flop synchroniser (sync), then a 4-state FSM with counter cnt[CNT_W-1:0].
- STABLE0: level=0, cnt=0. sync=1 -> ARM1.
- ARM1: on tick, cnt+1. sync=0 -> STABLE0, cnt=0 (glitch rejected, no pulse). On a tick where cnt+1 >= limit_eff -> STABLE1, press pulse, cnt=0.
- STABLE1: level=1. sync=0 -> ARM0, cnt=0.
- ARM0: mirror of ARM1. sync=1 -> STABLE1 with no pulse. Qualifying tick -> STABLE0, release pulse.
- limit_eff = (limit==0) ? 1 : limit, so limit 0 behaves as 1.
- limit is read live. A reduction mid-count takes effect at the next tick via the >= compare. cnt saturates at all-ones and never wraps.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Non-tick cycles never advance cnt. A sync reversal takes priority over a qualifying tick in the same cycle (reversal wins).

## Timing
- Reset: sync flops, FSM=STABLE0, cnt=0, rep_cnt=0, level=0, press=release=repeat=0. Takes effect on the first qzt_clk edge with reset high. Reset mid-count discards progress; no pulse is emitted.
- raw_in change to sync change: 2 qzt_clk cycles.
- Qualification: level changes on the qzt_clk edge after the limit_eff-th tick observed while in ARM. press/release are high in that same cycle, for exactly 1 cycle.
- Total latency ≈ 2 cycles + limit_eff tick periods (first tick may be partial).
- All outputs are registered; no combinational path from raw_in or tick.

## Configuration
- Macro AUTOREPEAT_EN.
- Defined: each channel has rep_cnt[CNT_W-1:0]. It is cleared on entry to STABLE1 and counts ticks while in STABLE1 or ARM0.
  - On reaching hold_limit (0 treated as 1): repeat pulses for 1 cycle and rep_cnt reloads to 0.
  - Each further repeat_limit ticks (0 treated as 1) produces another repeat pulse.
  - Leaving to STABLE0 clears rep_cnt and stops pulses.
- Undefined: repeat is tied to 0, hold_limit and repeat_limit are unused, and no rep_cnt logic is synthesised. Ports remain present.

## Test plan
- Clean press: limit=5, tick every 10 cycles, raw_in[0] 0->1 and held. level[0]=1 and press[0] is a single-cycle pulse in the cycle after the 5th tick following sync. No other channel moves.
- Bounce rejection: limit=5, raw_in[1] toggles every 3 ticks for 30 ticks, then stays 1. No press pulses while bouncing; exactly one press pulse 5 ticks after the final edge.
- Release and limit=0: raw_in[2] held then dropped with limit=0. Release pulse one cycle after the first tick following sync; level[2]=0.
- Reset mid-count: limit=10, raw_in[3]=1, reset asserted for 1 cycle after 6 ticks. Outputs 0 after the reset edge, no pulse. Counting restarts from 0, and press occurs 10 ticks after reset deasserts.
- Simultaneous: all channels rise in the same cycle with limit=3. All press bits pulse in the same cycle and level=all ones.
- AUTOREPEAT_EN: hold_limit=20, repeat_limit=4, hold channel 0 for 40 ticks after press. Repeat pulses at ticks 20, 24, 28, 32, 36, 40 after press. With the macro undefined, repeat stays 0.
